// File: rtl/score_glyph_scanner_pkg.sv
// Shared constants and types for the score overlay and the digit-sprite ROM.
// Glyph geometry here is the single source of truth for both sides of the ROM interface.
package score_glyph_scanner_pkg;

    localparam int unsigned GLYPH_W     = 4;
    localparam int unsigned GLYPH_H     = 7;
    localparam int unsigned DIGIT_PITCH = 5;
    localparam int unsigned NUM_DIGITS  = 2;
    localparam int unsigned COLOR_W     = 3;
    localparam int unsigned BCD_W       = 4;

    typedef logic [BCD_W-1:0]   bcd_digit_t;
    typedef logic [COLOR_W-1:0] color_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_score_counter.sv
// Two-digit BCD score: point increments with carry, saturates at 99, clear has priority.
module bcd_score_counter
    import score_glyph_scanner_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       point,
    input  logic       clear,
    output logic [7:0] score_bcd
);

    bcd_digit_t tens_q, tens_d;
    bcd_digit_t units_q, units_d;
    logic       at_max;

    assign at_max = (tens_q == BCD_MAX) && (units_q == BCD_MAX);

    always_comb begin
        tens_d  = tens_q;
        units_d = units_q;
        if (clear) begin
            tens_d  = '0;
            units_d = '0;
        end else if (point && !at_max) begin
            if (units_q == BCD_MAX) begin
                units_d = '0;
                tens_d  = tens_q + 4'd1;
            end else begin
                units_d = units_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens_q  <= '0;
            units_q <= '0;
        end else begin
            tens_q  <= tens_d;
            units_q <= units_d;
        end
    end

    assign score_bcd = {tens_q, units_q};

endmodule

// File: rtl/score_glyph_scanner.sv
// Score overlay: addresses the digit-sprite ROM from the pixel raster and composites its output.
// Define SCORE_LEADING_ZERO_BLANK_EN to blank the tens digit while it is zero.
module score_glyph_scanner
    import score_glyph_scanner_pkg::*;
#(
    parameter logic [9:0]  ORIGIN_X   = 10'd300,
    parameter logic [9:0]  ORIGIN_Y   = 10'd16,
    parameter int unsigned SCALE_LOG2 = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       point,
    input  logic       clear,
    input  logic       pix_valid,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic [2:0] bg_color,
    output logic [3:0] glyph_digit,
    output logic [2:0] glyph_x,
    output logic [2:0] glyph_y,
    input  logic [2:0] glyph_pix,
    output logic       out_valid,
    output logic [2:0] out_color,
    output logic [7:0] score_bcd
);

    bcd_score_counter u_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .point     (point),
        .clear     (clear),
        .score_bcd (score_bcd)
    );

    // Rendering reads only this frame-latched copy so digits never tear mid-frame.
    bcd_digit_t shadow_tens_q, shadow_units_q;
    logic       frame_start;

    assign frame_start = pix_valid && (pix_x == 10'd0) && (pix_y == 10'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_tens_q  <= '0;
            shadow_units_q <= '0;
        end else if (frame_start) begin
            shadow_tens_q  <= score_bcd[7:4];
            shadow_units_q <= score_bcd[3:0];
        end
    end

    logic [9:0] rx, ry, col, row;
    logic       tens_col, in_digit_area, blank, in_region;
    logic [3:0] glyph_digit_d;
    logic [2:0] glyph_x_d, glyph_y_d;

    always_comb begin
        rx            = pix_x - ORIGIN_X;
        ry            = pix_y - ORIGIN_Y;
        col           = rx >> SCALE_LOG2;
        row           = ry >> SCALE_LOG2;
        tens_col      = col < 10'(GLYPH_W);
        in_digit_area = pix_valid && (pix_x >= ORIGIN_X) && (pix_y >= ORIGIN_Y)
                        && (col < 10'(DIGIT_PITCH * NUM_DIGITS - 1))
                        && (col != 10'(GLYPH_W)) && (row < 10'(GLYPH_H));
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        blank         = tens_col && (shadow_tens_q == '0);
`else
        blank         = 1'b0;
`endif
        in_region     = in_digit_area && !blank;

        glyph_digit_d = glyph_digit;
        glyph_x_d     = glyph_x;
        glyph_y_d     = glyph_y;
        if (in_region) begin
            glyph_digit_d = tens_col ? shadow_tens_q : shadow_units_q;
            // Units columns are 5..8; the 3-bit wrap of col-5 yields 0..3.
            glyph_x_d     = tens_col ? col[2:0] : (col[2:0] - 3'(DIGIT_PITCH));
            glyph_y_d     = row[2:0];
        end
    end

    logic   s1_in_region_q, s1_valid_q;
    color_t s1_bg_q;
    logic   s2_in_region_q, s2_valid_q;
    color_t s2_bg_q;
    color_t out_color_d;

    always_comb begin
        out_color_d = '0;
        if (s2_valid_q) begin
            out_color_d = (s2_in_region_q && (glyph_pix != '0)) ? glyph_pix : s2_bg_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glyph_digit    <= '0;
            glyph_x        <= '0;
            glyph_y        <= '0;
            s1_in_region_q <= 1'b0;
            s1_valid_q     <= 1'b0;
            s1_bg_q        <= '0;
            s2_in_region_q <= 1'b0;
            s2_valid_q     <= 1'b0;
            s2_bg_q        <= '0;
            out_valid      <= 1'b0;
            out_color      <= '0;
        end else begin
            glyph_digit    <= glyph_digit_d;
            glyph_x        <= glyph_x_d;
            glyph_y        <= glyph_y_d;
            s1_in_region_q <= in_region;
            s1_valid_q     <= pix_valid;
            s1_bg_q        <= bg_color;
            s2_in_region_q <= s1_in_region_q;
            s2_valid_q     <= s1_valid_q;
            s2_bg_q        <= s1_bg_q;
            out_valid      <= s2_valid_q;
            out_color      <= out_color_d;
        end
    end

endmodule

// File: tb/tb_score_glyph_scanner.sv
// Self-checking bench for score_glyph_scanner: directed steps plus a random raster burst,
// all outputs compared against an arithmetic model of score, shadow and glyph placement.
module tb_score_glyph_scanner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       point, clear, pix_valid;
    logic [9:0] pix_x, pix_y;
    logic [2:0] bg_color;
    logic [3:0] glyph_digit;
    logic [2:0] glyph_x, glyph_y;
    logic [2:0] glyph_pix = 3'd0;
    logic       out_valid;
    logic [2:0] out_color;
    logic [7:0] score_bcd;

    int n_cmp  = 0;
    int n_fail = 0;
    int rom_mode = 0;
    int m_score  = 0;
    int m_shadow = 0;

    typedef struct {
        logic       v;
        logic [2:0] c;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    score_glyph_scanner dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .point       (point),
        .clear       (clear),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .bg_color    (bg_color),
        .glyph_digit (glyph_digit),
        .glyph_x     (glyph_x),
        .glyph_y     (glyph_y),
        .glyph_pix   (glyph_pix),
        .out_valid   (out_valid),
        .out_color   (out_color),
        .score_bcd   (score_bcd)
    );

    // Sprite ROM stand-in: arbitrary pattern with some transparent (zero) pixels.
    function automatic logic [2:0] rom_fn(input int d, input int x, input int y);
        if (rom_mode == 1) return 3'b101;
        if (rom_mode == 2) return 3'b000;
        return 3'((d * 3 + y * 5 + x * 7 + 1) % 8);
    endfunction

    always @(posedge clk) glyph_pix <= rom_fn(int'(glyph_digit), int'(glyph_x), int'(glyph_y));

    function automatic logic [7:0] to_bcd(input int s);
        return {4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [2:0] expect_color(input logic v, input int x, input int y,
                                                input int bg);
        int gx, gy, d, tens;
        logic [2:0] c;
        if (!v) return 3'd0;
        if (x < 300 || y < 16) return 3'(bg);
        gx = (x - 300) / 4;
        gy = (y - 16) / 4;
        if (gx >= 9 || gx == 4 || gy >= 7) return 3'(bg);
        tens = m_shadow / 10;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        if (gx < 4 && tens == 0) return 3'(bg);
`endif
        d = (gx < 4) ? tens : m_shadow % 10;
        c = rom_fn(d, gx % 5, gy);
        return (c != 3'd0) ? c : 3'(bg);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic v, input int x, input int y, input int bg,
                       input logic pt, input logic clr);
        exp_t e;
        @(negedge clk);
        pix_valid = v;
        pix_x     = 10'(x);
        pix_y     = 10'(y);
        bg_color  = 3'(bg);
        point     = pt;
        clear     = clr;
        e.v = v;
        e.c = expect_color(v, x, y, bg);
        q.push_back(e);
        if (v && x == 0 && y == 0) m_shadow = m_score;
        if (clr) m_score = 0;
        else if (pt && m_score < 99) m_score++;
        @(posedge clk);
        #1;
        point = 1'b0;
        clear = 1'b0;
        if (q.size() == 3) begin
            e = q.pop_front();
            chk("out_valid", 32'(out_valid), 32'(e.v));
            chk("out_color", 32'(out_color), 32'(e.c));
        end
        chk("score_bcd", 32'(score_bcd), 32'(to_bcd(m_score)));
    endtask

    task automatic drain();
        repeat (3) cyc(1'b0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        pix_valid = 1'b0;
        point     = 1'b0;
        clear     = 1'b0;
        q.delete();
        m_score  = 0;
        m_shadow = 0;
        #2;
        chk("rst_score", 32'(score_bcd), 32'h0);
        chk("rst_digit", 32'(glyph_digit), 32'h0);
        chk("rst_gx", 32'(glyph_x), 32'h0);
        chk("rst_gy", 32'(glyph_y), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_color", 32'(out_color), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1; point = 1'b0; clear = 1'b0; pix_valid = 1'b0;
        pix_x = '0; pix_y = '0; bg_color = '0;
        do_reset();

        // Score 12, shadow refresh, then address checks on tens and units digits.
        repeat (12) cyc(1'b0, 0, 0, 0, 1'b1, 1'b0);
        chk("score_12", 32'(score_bcd), 32'h12);
        cyc(1'b1, 0, 0, 3, 1'b0, 1'b0);
        cyc(1'b1, 304, 16, 2, 1'b0, 1'b0);
        drain();
        chk("tens_digit", 32'(glyph_digit), 32'd1);
        chk("tens_gx", 32'(glyph_x), 32'd1);
        chk("tens_gy", 32'(glyph_y), 32'd0);
        cyc(1'b1, 324, 20, 2, 1'b0, 1'b0);
        drain();
        chk("units_digit", 32'(glyph_digit), 32'd2);
        chk("units_gx", 32'(glyph_x), 32'd1);
        chk("units_gy", 32'(glyph_y), 32'd1);

        // Opaque and transparent ROM data.
        rom_mode = 1;
        cyc(1'b1, 304, 16, 2, 1'b0, 1'b0);
        drain();
        rom_mode = 2;
        cyc(1'b1, 304, 16, 6, 1'b0, 1'b0);
        drain();
        rom_mode = 1;
        // Gap column, left of origin, row 7: all background.
        cyc(1'b1, 316, 16, 4, 1'b0, 1'b0);
        cyc(1'b1, 299, 16, 3, 1'b0, 1'b0);
        cyc(1'b1, 300, 44, 1, 1'b0, 1'b0);
        drain();
        rom_mode = 0;

        // Mid-frame point: units stays 2 until the next frame start.
        cyc(1'b0, 0, 0, 0, 1'b1, 1'b0);
        cyc(1'b1, 324, 16, 2, 1'b0, 1'b0);
        drain();
        chk("pre_frame_units", 32'(glyph_digit), 32'd2);
        cyc(1'b1, 0, 0, 0, 1'b0, 1'b0);
        cyc(1'b1, 324, 16, 2, 1'b0, 1'b0);
        drain();
        chk("post_frame_units", 32'(glyph_digit), 32'd3);

        // Random raster traffic over and around the digit area.
        for (int i = 0; i < 400; i++) begin
            logic v, pt, clr;
            int x, y;
            v   = ($urandom_range(0, 9) != 0);
            x   = 290 + int'($urandom_range(0, 45));
            y   = 10 + int'($urandom_range(0, 35));
            if ($urandom_range(0, 39) == 0) begin x = 0; y = 0; end
            pt  = ($urandom_range(0, 5) == 0);
            clr = ($urandom_range(0, 99) == 0);
            cyc(v, x, y, int'($urandom_range(0, 7)), pt, clr);
        end
        drain();

        // Saturation at 99, then clear beats point.
        cyc(1'b0, 0, 0, 0, 1'b0, 1'b1);
        repeat (105) cyc(1'b0, 0, 0, 0, 1'b1, 1'b0);
        chk("score_sat", 32'(score_bcd), 32'h99);
        cyc(1'b0, 0, 0, 0, 1'b1, 1'b1);
        chk("clear_wins", 32'(score_bcd), 32'h00);

        // Score 05: tens digit drawn as 0, or blanked when the macro is defined.
        repeat (5) cyc(1'b0, 0, 0, 0, 1'b1, 1'b0);
        cyc(1'b1, 0, 0, 0, 1'b0, 1'b0);
        for (int gy = 0; gy < 7; gy++)
            for (int gx = 0; gx < 9; gx++)
                cyc(1'b1, 300 + 4 * gx + 1, 16 + 4 * gy + 2, 7 - gx % 8, 1'b0, 1'b0);
        drain();

        // Reset mid-frame, then a fresh frame renders 00.
        cyc(1'b1, 304, 16, 2, 1'b0, 1'b0);
        cyc(1'b1, 308, 16, 2, 1'b0, 1'b0);
        do_reset();
        cyc(1'b1, 0, 0, 1, 1'b0, 1'b0);
        for (int gx = 0; gx < 9; gx++) cyc(1'b1, 300 + 4 * gx, 20, 5, 1'b0, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/score_glyph_scanner.md
Name: score_glyph_scanner

Overview:
- Client side of the digit-sprite ROM. Keeps a two-digit BCD score and walks the pixel raster.
- Drives digit select and glyph x/y into the ROM (4x7 glyphs, addr = 4*y + x, one-cycle registered read, 3-bit colour out).
- Overlays the returned glyph pixels on the background pixel stream. Sits between the VGA timing/pong renderer and the colour output.

Parameters:
- ORIGIN_X, 10'd300, screen x of left edge of tens digit
- ORIGIN_Y, 10'd16, screen y of top row of glyphs
- SCALE_LOG2, 2, each glyph pixel is 2^SCALE_LOG2 x 2^SCALE_LOG2 screen pixels

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- point  in  1  one-cycle pulse: add one to score
- clear  in  1  one-cycle pulse: zero score
- pix_valid  in  1  pixel stream qualifier (active video)
- pix_x  in  10  current pixel column
- pix_y  in  10  current pixel row
- bg_color  in  3  background colour for this pixel
- glyph_digit  out  4  digit select to ROM (0-9)
- glyph_x  out  3  glyph column to ROM (0-3)
- glyph_y  out  3  glyph row to ROM (0-6)
- glyph_pix  in  3  ROM data, valid one cycle after glyph_* sampled
- out_valid  out  1  delayed pix_valid
- out_color  out  3  composited colour
- score_bcd  out  8  live score {tens, units}

Behaviour:
- Reset (async, rst_n=0):
  - score_bcd=0, shadow score=0.
  - glyph_digit/x/y=0, out_valid=0, out_color=0.
  - All pipeline flags cleared.
- Score counter (BCD):
  - point: units+1; units 9->0 carries into tens.
  - Saturates at 99; point at 99 has no effect.
  - clear: next cycle score=00. clear and point in the same cycle: clear wins.
- Shadow score:
  - Loaded from score_bcd on any cycle with pix_valid=1, pix_x=0, pix_y=0.
  - Rendering uses only the shadow, so the digits never tear mid-frame.
- Stage 1, registered at edge after input:
  - rx = pix_x - ORIGIN_X, ry = pix_y - ORIGIN_Y, 10-bit unsigned.
  - col = rx >> SCALE_LOG2, row = ry >> SCALE_LOG2.
  - in_region = pix_valid & pix_x>=ORIGIN_X & pix_y>=ORIGIN_Y & col<9 & col!=4 & row<7.
  - col 0-3: glyph_digit=shadow tens, glyph_x=col.
  - col 5-8: glyph_digit=shadow units, glyph_x=col-5.
  - glyph_y=row.
  - Outside the region: glyph_digit/x/y hold their previous value.
  - in_region, pix_valid and bg_color are registered alongside.
- Stage 2, ROM cycle: in_region, pix_valid and bg_color are delayed one more cycle.
- Stage 3, registered output:
  - out_valid = delayed pix_valid.
  - out_color = glyph_pix when delayed in_region=1 and glyph_pix!=0, else delayed bg_color.
  - out_color=0 when delayed pix_valid=0.
- Latency: exactly 3 clocks from pix_* to out_*. Fully pipelined, one pixel per clock, no stalls.
- Reset mid-frame: pipeline flushes to invalid; the next frame renders 00.

Optional Feature:
- Macro: SCORE_LEADING_ZERO_BLANK_EN.
- Defined: when shadow tens=0, the tens digit columns (col 0-3) force in_region=0, so the background shows and score 7 renders as a single "7".
- Undefined: the tens digit is always drawn, so score 7 renders as "07".

Decomposition:
- Shared package: GLYPH_W=4, GLYPH_H=7, DIGIT_PITCH=5, NUM_DIGITS=2, colour width 3, BCD digit type.
- The scoreboard sprite ROM reuses the glyph constants from this package.
- One natural sub-module: bcd_score_counter (point/clear/saturate, BCD out). The scanner pipeline stays in this module.

Test Plan:
- Reset, then 12 point pulses -> score_bcd=8'h12; with shadow refreshed, tens reads ROM digit 1 and units reads digit 2.
- 105 point pulses -> score_bcd=8'h99 after the 99th pulse and stays 8'h99. Then clear and point in the same cycle -> 8'h00.
- SCALE_LOG2=2, pixel (304,16) -> three cycles later glyph_digit=tens, glyph_x=1, glyph_y=0. out_color=glyph_pix when ROM model returns 3'b101; out_color=bg_color when ROM model returns 0.
- Pixel (316,16), the gap column -> out_color=bg_color. Pixels (299,16) and (300,44) (row 7) -> bg_color.
- point pulse mid-frame -> displayed digits stay unchanged until the pixel (0,0) valid cycle, then show the new value.
- Score 05, macro defined -> tens region shows bg_color. Macro undefined -> digit-0 glyph drawn.
